spi_mem_arbiter: RTL and testbench
==================================

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning SPI address width in bits; legal values are 8, 16 and 24.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port f_req, input, 1, fetch-port request; held high until f_ready.
REQ-005 SHALL have port f_addr, input, ADDR_W, fetch address; stable while f_req is high.
REQ-006 SHALL have port f_ready, output, 1, one-cycle fetch-completion pulse.
REQ-007 SHALL have port f_rdata, output, 8, fetch read byte.
REQ-008 SHALL have port d_req, input, 1, data-port request; held high until d_ready.
REQ-009 SHALL have port d_we, input, 1, data-port write enable; 1 = write, 0 = read.
REQ-010 SHALL have port d_addr, input, ADDR_W, data address; stable while d_req is high.
REQ-011 SHALL have port d_wdata, input, 8, data-port write byte.
REQ-012 SHALL have port d_ready, output, 1, one-cycle data-completion pulse.
REQ-013 SHALL have port d_rdata, output, 8, data-port read byte.
REQ-014 SHALL have port spi_clk, output, 1, SPI clock, mode 0, clk/2.
REQ-015 SHALL have port spi_mosi, output, 1, SPI serial out, MSB first.
REQ-016 SHALL have port spi_miso, input, 1, SPI serial in.
REQ-017 SHALL have port spi_cs_n, output, 1, active-low chip select.
REQ-018 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> CMD -> ADDR -> DATA -> GAP -> IDLE.
REQ-020 SHALL, in IDLE with exactly one requester asserted, grant that requester on the next edge.
REQ-021 SHALL, in IDLE with both requesters asserted, grant the port not granted last (round-robin).
REQ-022 SHALL latch the granted port's address, we and wdata at grant; later input changes are ignored.
REQ-023 SHALL treat a fetch as a read and send command byte 0x03 for a read and 0x02 for a write.
REQ-024 SHALL send the command in CMD (8 bits), the address MSB-first in ADDR (ADDR_W bits), then in DATA either shift out wdata (write) or shift in 8 bits from spi_miso (read).
REQ-025 SHALL use 2 clk cycles per bit: phase 0 has spi_clk low with spi_mosi updated; phase 1 has spi_clk high with spi_miso sampled on entry to phase 1.
REQ-026 SHALL drive spi_cs_n low from the CMD entry to the DATA exit, and high in IDLE and GAP.
REQ-027 SHALL hold GAP for 2 cycles, giving a minimum cs_n-high time of 3 cycles including IDLE.
REQ-028 SHALL assert the granted port's ready for exactly 1 cycle on GAP entry.
REQ-029 SHALL load the corresponding rdata register in that same ready cycle, keep it until the port's next read, and leave it unchanged on a write.
REQ-030 SHALL, on a read, set latency from the grant edge to ready equal to 2*(16+ADDR_W)+1 cycles (65 at ADDR_W=16).
REQ-031 SHALL, if req deasserts mid-transaction, still complete the transaction and pulse ready.
REQ-032 SHALL never assert both ready outputs in the same cycle.
REQ-033 SHALL keep spi_clk low whenever spi_cs_n is high, and keep spi_mosi at 0 in IDLE.

Reset
REQ-034 SHALL, while rst is high, force state IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, f_ready=0, d_ready=0, f_rdata=0x00, d_rdata=0x00 and busy=0, with the last grant set to data so that fetch wins the first tie.
REQ-035 SHALL, on rst assertion mid-transaction, abort immediately without the clock edge, pulse no ready, and raise spi_cs_n asynchronously.
REQ-036 SHALL make rst deassertion effective on the next clk edge, with a request accepted no earlier than 1 cycle after it.

Verification
REQ-037 SHALL be verified by: f_req with f_addr=0x1234 and the model returning 0xA5 -> mosi carries 0x03,0x12,0x34; f_ready is pulsed 65 cycles after grant; f_rdata=0xA5.
REQ-038 SHALL be verified by: d_req, d_we=1, d_addr=0x00FF, d_wdata=0x3C -> mosi carries 0x02,0x00,0xFF,0x3C; d_ready pulses once; d_rdata is unchanged.
REQ-039 SHALL be verified by: f_req and d_req rising together after reset -> fetch served first, data second, each ready pulsing once, with cs_n high for at least 3 cycles between them.
REQ-040 SHALL be verified by: both ports requesting continuously for 4 transactions -> grants alternate F,D,F,D.
REQ-041 SHALL be verified by: rst pulsed in the ADDR state -> cs_n=1 and spi_clk=0 in the same cycle, no ready pulse, and a new fetch after release completes correctly.
REQ-042 SHALL be verified by: f_req dropped during DATA -> transaction completes and f_ready pulses once.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one SPI memory, mode 0 at clk/2, round-robin on ties.
// Each transaction sends command, address and one data byte, then a 2-cycle cs_n-high gap.
module spi_mem_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic [7:0]        f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_wdata,
  output logic              d_ready,
  output logic [7:0]        d_rdata,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n,
  output logic              busy
);

  localparam int SR_W = 16 + ADDR_W;
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_W - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

  state_t          state, state_nxt;
  logic            phase;
  logic [4:0]      cnt;
  logic            gap_cnt;
  logic [SR_W-1:0] sr;
  logic [7:0]      rx;
  logic            cur_d;
  logic            cur_we;
  logic            last_d;

  logic            grant;
  logic            grant_d;
  logic            shifting;
  logic            bit_end;

  assign shifting = (state == CMD) || (state == ADDR) || (state == DATA);
  assign bit_end  = shifting && phase && (cnt == 5'd0);

  assign busy     = (state != IDLE);
  assign spi_cs_n = !shifting;
  assign spi_clk  = shifting && phase;
  assign spi_mosi = shifting && sr[SR_W-1];

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        // Fetch wins a tie unless it was the port served last.
        if (f_req && (!d_req || last_d)) begin
          grant     = 1'b1;
          state_nxt = CMD;
        end else if (d_req) begin
          grant     = 1'b1;
          grant_d   = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD:     if (bit_end) state_nxt = ADDR;
      ADDR:    if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end) state_nxt = GAP;
      GAP:     if (gap_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 1'b0;
      cnt     <= 5'd0;
      gap_cnt <= 1'b0;
      sr      <= '0;
      rx      <= 8'h00;
      cur_d   <= 1'b0;
      cur_we  <= 1'b0;
      last_d  <= 1'b1;
      f_ready <= 1'b0;
      d_ready <= 1'b0;
      f_rdata <= 8'h00;
      d_rdata <= 8'h00;
    end else begin
      state   <= state_nxt;
      f_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant) begin
        phase   <= 1'b0;
        cnt     <= 5'd7;
        gap_cnt <= 1'b0;
        cur_d   <= grant_d;
        last_d  <= grant_d;
        cur_we  <= grant_d && d_we;
        sr      <= {(grant_d && d_we) ? 8'h02 : 8'h03,
                    grant_d ? d_addr : f_addr,
                    (grant_d && d_we) ? d_wdata : 8'h00};
      end else if (shifting) begin
        phase <= !phase;
        if (!phase) begin
          rx <= {rx[6:0], spi_miso};
        end else begin
          // Leaving phase 1 starts the next bit: advance mosi and the segment counter.
          sr <= sr << 1;
          if (cnt != 5'd0)       cnt <= cnt - 5'd1;
          else if (state == CMD) cnt <= ADDR_LAST;
          else                   cnt <= 5'd7;
        end
        if (state == DATA && bit_end) begin
          f_ready <= !cur_d;
          d_ready <= cur_d;
          if (!cur_we) begin
            if (cur_d) d_rdata <= rx;
            else       f_rdata <= rx;
          end
        end
      end else if (state == GAP) begin
        gap_cnt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a behavioural SPI memory slave.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = 16'h0;
  logic        f_ready;
  logic [7:0]  f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'h0;
  logic [7:0]  d_wdata = 8'h0;
  logic        d_ready;
  logic [7:0]  d_rdata;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs_n;
  logic        busy;

  int checks = 0;
  int errors = 0;

  spi_mem_arbiter #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .busy(busy)
  );

  always #5 clk = ~clk;

  // SPI slave model: records mosi on rising spi_clk, returns resp during the data byte.
  logic [7:0]  resp = 8'h00;
  logic [7:0]  resp_sr = 8'h00;
  logic [63:0] mosi_bits = 64'h0;
  int          nbits = 0;

  assign spi_miso = (nbits >= 24) ? resp_sr[7] : 1'b0;

  always @(posedge spi_clk or negedge spi_cs_n) begin
    if (!spi_clk) begin
      nbits     <= 0;
      mosi_bits <= 64'h0;
      resp_sr   <= resp;
    end else begin
      mosi_bits <= {mosi_bits[62:0], spi_mosi};
      nbits     <= nbits + 1;
      if (nbits >= 24) resp_sr <= {resp_sr[6:0], 1'b0};
    end
  end

  int f_pulses = 0;
  int d_pulses = 0;
  int both_cnt = 0;
  int pin_viol = 0;
  int hi_run = 0;
  int last_hi_run = 0;

  always @(posedge clk) begin
    #1;
    if (f_ready) f_pulses++;
    if (d_ready) d_pulses++;
    if (f_ready && d_ready) both_cnt++;
    if (spi_cs_n && spi_clk) pin_viol++;
    if (!busy && spi_mosi) pin_viol++;
    if (spi_cs_n) hi_run++;
    else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end
  end

  // Waits (bounded) for either ready; n counts negedges, -1 on timeout.
  task automatic wait_ready(output logic is_d, output int n);
    bit done;
    done = 0;
    n    = 0;
    is_d = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (f_ready || d_ready) begin
        is_d = d_ready;
        done = 1;
      end
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rst_spi_clk: got %b want 0", spi_clk); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", spi_mosi); end
    checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL rst_f_ready: got %b want 0", f_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready: got %b want 0", d_ready); end
    checks++; if (f_rdata !== 8'h00) begin errors++; $display("FAIL rst_f_rdata: got %h want 00", f_rdata); end
    checks++; if (d_rdata !== 8'h00) begin errors++; $display("FAIL rst_d_rdata: got %h want 00", d_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got %b want 0", busy); end
  endtask

  task automatic test_fetch_read();
    logic is_d;
    int   n;
    resp   = 8'hA5;
    f_addr = 16'h1234;
    f_req  = 1'b1;
    @(negedge clk);
    f_addr = 16'hBEEF;
    wait_ready(is_d, n);
    f_req = 1'b0;
    checks++; if (n + 1 !== 65) begin errors++; $display("FAIL fetch_latency: got %0d want 65", n + 1); end
    checks++; if (is_d !== 1'b0) begin errors++; $display("FAIL fetch_port: got d_ready want f_ready"); end
    checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL fetch_rdata: got %h want a5", f_rdata); end
    checks++; if (mosi_bits[31:8] !== 24'h031234) begin errors++; $display("FAIL fetch_mosi: got %h want 031234", mosi_bits[31:8]); end
    @(negedge clk);
    checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %b want 0", f_ready); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tie();
    logic is_d;
    int   n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    resp   = 8'h5A;
    f_addr = 16'h0100;
    d_addr = 16'h0200;
    d_we   = 1'b0;
    f_req  = 1'b1;
    d_req  = 1'b1;
    wait_ready(is_d, n);
    f_req = 1'b0;
    checks++; if (n < 0 || is_d !== 1'b0) begin errors++; $display("FAIL tie_first: got is_d=%b n=%0d want fetch", is_d, n); end
    checks++; if (f_rdata !== 8'h5A) begin errors++; $display("FAIL tie_f_rdata: got %h want 5a", f_rdata); end
    wait_ready(is_d, n);
    d_req = 1'b0;
    checks++; if (n < 0 || is_d !== 1'b1) begin errors++; $display("FAIL tie_second: got is_d=%b n=%0d want data", is_d, n); end
    checks++; if (d_rdata !== 8'h5A) begin errors++; $display("FAIL tie_d_rdata: got %h want 5a", d_rdata); end
    checks++; if (last_hi_run < 3) begin errors++; $display("FAIL tie_cs_gap: got %0d want >=3", last_hi_run); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic is_d;
    int   n;
    int   p0;
    p0      = d_pulses;
    d_we    = 1'b1;
    d_addr  = 16'h00FF;
    d_wdata = 8'h3C;
    d_req   = 1'b1;
    wait_ready(is_d, n);
    d_req = 1'b0;
    d_we  = 1'b0;
    checks++; if (n < 0 || is_d !== 1'b1) begin errors++; $display("FAIL write_port: got is_d=%b n=%0d want data", is_d, n); end
    checks++; if (mosi_bits[31:0] !== 32'h0200FF3C) begin errors++; $display("FAIL write_mosi: got %h want 0200ff3c", mosi_bits[31:0]); end
    checks++; if (d_rdata !== 8'h5A) begin errors++; $display("FAIL write_d_rdata: got %h want 5a", d_rdata); end
    repeat (5) @(negedge clk);
    checks++; if (d_pulses !== p0 + 1) begin errors++; $display("FAIL write_pulses: got %0d want %0d", d_pulses, p0 + 1); end
  endtask

  task automatic test_round_robin();
    logic is_d;
    int   n;
    logic [3:0] order;
    order = 4'b0000;
    f_req = 1'b1;
    d_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ready(is_d, n);
      order[3-i] = (n < 0) ? 1'bx : is_d;
    end
    f_req = 1'b0;
    d_req = 1'b0;
    checks++; if (order !== 4'b0101) begin errors++; $display("FAIL rr_order: got %b want 0101 (F,D,F,D)", order); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_drop_req();
    logic is_d;
    int   n;
    int   p0;
    p0     = f_pulses;
    resp   = 8'h81;
    f_addr = 16'h0042;
    f_req  = 1'b1;
    repeat (55) @(negedge clk);
    f_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b want 1", busy); end
    wait_ready(is_d, n);
    checks++; if (n < 0 || n + 55 !== 65) begin errors++; $display("FAIL drop_latency: got %0d want 65", n + 55); end
    checks++; if (f_rdata !== 8'h81) begin errors++; $display("FAIL drop_rdata: got %h want 81", f_rdata); end
    repeat (5) @(negedge clk);
    checks++; if (f_pulses !== p0 + 1) begin errors++; $display("FAIL drop_pulses: got %0d want %0d", f_pulses, p0 + 1); end
  endtask

  task automatic test_reset_abort();
    logic is_d;
    int   n;
    int   p0;
    p0     = f_pulses;
    resp   = 8'hC3;
    f_addr = 16'h1234;
    f_req  = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL abort_active: got cs_n=%b want 0", spi_cs_n); end
    #2 rst = 1'b1;
    #1;
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL abort_spi_clk: got %b want 0", spi_clk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    f_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (f_pulses !== p0) begin errors++; $display("FAIL abort_no_ready: got %0d want %0d", f_pulses, p0); end
    resp   = 8'h3E;
    f_addr = 16'h0777;
    f_req  = 1'b1;
    wait_ready(is_d, n);
    f_req = 1'b0;
    checks++; if (n !== 65) begin errors++; $display("FAIL abort_refetch_latency: got %0d want 65", n); end
    checks++; if (f_rdata !== 8'h3E) begin errors++; $display("FAIL abort_refetch_rdata: got %h want 3e", f_rdata); end
    checks++; if (mosi_bits[31:8] !== 24'h030777) begin errors++; $display("FAIL abort_refetch_mosi: got %h want 030777", mosi_bits[31:8]); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_invariants();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL both_ready: got %0d want 0", both_cnt); end
    checks++; if (pin_viol !== 0) begin errors++; $display("FAIL idle_pins: got %0d want 0", pin_viol); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_tie();
    test_write();
    test_round_robin();
    test_drop_req();
    test_reset_abort();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
